// File: rtl/ps2_keyboard_receiver_if.sv
// PS/2 receiver bundle: raw keyboard pins in, decoded scan-code outputs back to the consumer.
// The master side is the keyboard/host environment; the slave side is the receiver.
interface ps2_keyboard_receiver_if;
  logic       PS2_Clk;
  logic       PS2_Data;
  logic [7:0] Kb_Byte;
  logic       Kb_Valid;
  logic       Kb_Break;
  logic       Kb_Extended;
  logic       Frame_Error;
  logic       Busy;

  modport master (
    output PS2_Clk, PS2_Data,
    input  Kb_Byte, Kb_Valid, Kb_Break, Kb_Extended, Frame_Error, Busy
  );

  modport slave (
    input  PS2_Clk, PS2_Data,
    output Kb_Byte, Kb_Valid, Kb_Break, Kb_Extended, Frame_Error, Busy
  );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the pins, checks framing,
// and folds F0/E0 prefixes so only complete key codes are reported.
module ps2_keyboard_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic                  Fast_Clock,
  input  logic                  Reset,
  ps2_keyboard_receiver_if.slave bus
);

  localparam int unsigned FltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FltW-1:0] r_flt_cnt, w_flt_cnt_d;
  logic            r_flt_level, w_flt_level_d, r_flt_prev;
  logic            w_fall;

  state_e               r_state, w_state_d;
  logic [7:0]           r_shift, w_shift_d;
  logic [2:0]           r_bit_cnt, w_bit_cnt_d;
  logic                 r_par, w_par_d;
  logic [TIMEOUT_W-1:0] r_to_cnt, w_to_cnt_d;
  logic                 w_timeout;
  logic                 r_pend_brk, w_pend_brk_d, r_pend_ext, w_pend_ext_d;
  logic [7:0]           r_kb_byte, w_kb_byte_d;
  logic                 r_kb_brk, w_kb_brk_d, r_kb_ext, w_kb_ext_d;
  logic                 r_kb_valid, w_kb_valid_d, r_frame_err, w_frame_err_d;

  // Pins idle high, so the synchronisers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_flt_cnt   <= '0;
      r_flt_level <= 1'b1;
      r_flt_prev  <= 1'b1;
    end else begin
      r_clk_s1    <= bus.PS2_Clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= bus.PS2_Data;
      r_dat_s2    <= r_dat_s1;
      r_flt_cnt   <= w_flt_cnt_d;
      r_flt_level <= w_flt_level_d;
      r_flt_prev  <= r_flt_level;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any agreement restarts it.
  always_comb begin
    w_flt_cnt_d   = r_flt_cnt;
    w_flt_level_d = r_flt_level;
    if (r_clk_s2 == r_flt_level) begin
      w_flt_cnt_d = '0;
    end else if (r_flt_cnt == FltW'(FILTER_LEN - 1)) begin
      w_flt_level_d = r_clk_s2;
      w_flt_cnt_d   = '0;
    end else begin
      w_flt_cnt_d = r_flt_cnt + FltW'(1);
    end
  end

  assign w_fall = r_flt_prev & ~r_flt_level;

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= StIdle;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_pend_brk  <= 1'b0;
      r_pend_ext  <= 1'b0;
      r_kb_byte   <= '0;
      r_kb_brk    <= 1'b0;
      r_kb_ext    <= 1'b0;
      r_kb_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_shift     <= w_shift_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_par       <= w_par_d;
      r_to_cnt    <= w_to_cnt_d;
      r_pend_brk  <= w_pend_brk_d;
      r_pend_ext  <= w_pend_ext_d;
      r_kb_byte   <= w_kb_byte_d;
      r_kb_brk    <= w_kb_brk_d;
      r_kb_ext    <= w_kb_ext_d;
      r_kb_valid  <= w_kb_valid_d;
      r_frame_err <= w_frame_err_d;
    end
  end

  // An edge in the same cycle as the timeout wins, so the timeout is masked by w_fall.
  assign w_timeout = (r_state != StIdle) && !w_fall &&
                     (r_to_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_d     = r_state;
    w_shift_d     = r_shift;
    w_bit_cnt_d   = r_bit_cnt;
    w_par_d       = r_par;
    w_pend_brk_d  = r_pend_brk;
    w_pend_ext_d  = r_pend_ext;
    w_kb_byte_d   = r_kb_byte;
    w_kb_brk_d    = r_kb_brk;
    w_kb_ext_d    = r_kb_ext;
    w_kb_valid_d  = 1'b0;
    w_frame_err_d = 1'b0;

    if (w_fall || (r_state == StIdle)) begin
      w_to_cnt_d = '0;
    end else begin
      w_to_cnt_d = r_to_cnt + TIMEOUT_W'(1);
    end

    if (w_timeout) begin
      w_state_d     = StIdle;
      w_frame_err_d = 1'b1;
      w_pend_brk_d  = 1'b0;
      w_pend_ext_d  = 1'b0;
      w_to_cnt_d    = '0;
    end else if (w_fall) begin
      unique case (r_state)
        StIdle: begin
          if (!r_dat_s2) begin
            w_state_d   = StData;
            w_bit_cnt_d = '0;
          end else begin
            w_frame_err_d = 1'b1;
            w_pend_brk_d  = 1'b0;
            w_pend_ext_d  = 1'b0;
          end
        end
        StData: begin
          w_shift_d   = {r_dat_s2, r_shift[7:1]};
          w_bit_cnt_d = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_d = StParity;
        end
        StParity: begin
          w_par_d   = r_dat_s2;
          w_state_d = StStop;
        end
        StStop: begin
          w_state_d = StIdle;
          if (r_dat_s2 && (^{r_shift, r_par})) begin
            if (r_shift == 8'hF0) begin
              w_pend_brk_d = 1'b1;
            end else if (r_shift == 8'hE0) begin
              w_pend_ext_d = 1'b1;
            end else begin
              w_kb_byte_d  = r_shift;
              w_kb_brk_d   = r_pend_brk;
              w_kb_ext_d   = r_pend_ext;
              w_kb_valid_d = 1'b1;
              w_pend_brk_d = 1'b0;
              w_pend_ext_d = 1'b0;
            end
          end else begin
            w_frame_err_d = 1'b1;
            w_pend_brk_d  = 1'b0;
            w_pend_ext_d  = 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.Kb_Byte     = r_kb_byte;
  assign bus.Kb_Valid    = r_kb_valid;
  assign bus.Kb_Break    = r_kb_brk;
  assign bus.Kb_Extended = r_kb_ext;
  assign bus.Frame_Error = r_frame_err;
  assign bus.Busy        = (r_state != StIdle);

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for the PS/2 receiver: frames are bit-banged onto the pins and the expected
// codes are queued, then matched against each Kb_Valid pulse.
module tb_ps2_keyboard_receiver;

  localparam int unsigned FLT  = 8;
  localparam int unsigned TO   = 2000;
  localparam int          LOW  = 12;
  localparam int          HIGH = 12;

  typedef struct packed {
    logic [7:0] b;
    logic       brk;
    logic       ext;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_keyboard_receiver_if ifc ();

  ps2_keyboard_receiver #(
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (16)
  ) dut (
    .Fast_Clock(clk),
    .Reset     (rst),
    .bus       (ifc)
  );

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_err   = 0;
  int   n_ferr  = 0;
  int   n_valid = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bit(input logic v, input bit glitch);
    @(negedge clk);
    ifc.PS2_Data = v;
    repeat (2) @(negedge clk);
    ifc.PS2_Clk = 1'b0;
    repeat (LOW) @(negedge clk);
    ifc.PS2_Clk = 1'b1;
    repeat (HIGH) @(negedge clk);
    if (glitch) begin
      ifc.PS2_Clk = 1'b0;
      repeat (3) @(negedge clk);
      ifc.PS2_Clk = 1'b1;
      repeat (HIGH) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input int glitch_at);
    logic [10:0] fr;
    fr = mk_frame(b, bad_par);
    for (int i = 0; i < nbits; i++) send_bit(fr[i], (i == glitch_at));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
  endtask

  // Scoreboard side: every valid pulse pops one expected code.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ifc.Kb_Valid || ifc.Frame_Error)
        chk("valid_error_exclusive", 32'(ifc.Kb_Valid & ifc.Frame_Error), 0);
      if (ifc.Frame_Error) n_ferr++;
      if (ifc.Kb_Valid) begin
        n_valid++;
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(ifc.Kb_Valid), 0);
        end else begin
          e = q.pop_front();
          chk("kb_byte", ifc.Kb_Byte, e.b);
          chk("kb_break", 32'(ifc.Kb_Break), 32'(e.brk));
          chk("kb_extended", 32'(ifc.Kb_Extended), 32'(e.ext));
        end
      end
    end
  end

  initial begin
    logic [10:0] fr;
    int          lat;
    int          f0;
    int          v0;

    ifc.PS2_Clk  = 1'b1;
    ifc.PS2_Data = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_byte", ifc.Kb_Byte, 0);
    chk("reset_valid", 32'(ifc.Kb_Valid), 0);
    chk("reset_break", 32'(ifc.Kb_Break), 0);
    chk("reset_ext", 32'(ifc.Kb_Extended), 0);
    chk("reset_ferr", 32'(ifc.Frame_Error), 0);
    chk("reset_busy", 32'(ifc.Busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Plain 0x1C with latency measured from the raw stop-bit fall.
    q.push_back('{b: 8'h1C, brk: 1'b0, ext: 1'b0});
    fr = mk_frame(8'h1C, 1'b0);
    chk("parity_of_1c", 32'(fr[9]), 0);
    send_bit(fr[0], 1'b0);
    chk("busy_after_start", 32'(ifc.Busy), 1);
    for (int i = 1; i < 10; i++) send_bit(fr[i], 1'b0);
    @(negedge clk);
    ifc.PS2_Data = 1'b1;
    repeat (2) @(negedge clk);
    ifc.PS2_Clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (ifc.Kb_Valid) begin
        lat = k;
        break;
      end
    end
    chk("valid_latency", lat, 2 + FLT + 1);
    repeat (LOW) @(negedge clk);
    ifc.PS2_Clk = 1'b1;
    repeat (HIGH) @(negedge clk);
    chk("busy_after_frame", 32'(ifc.Busy), 0);
    drain();

    // Break prefix: F0 alone must not pulse.
    v0 = n_valid;
    send_frame(8'hF0, 1'b0, 11, -1);
    repeat (5) @(negedge clk);
    chk("f0_no_valid", n_valid - v0, 0);
    q.push_back('{b: 8'h1C, brk: 1'b1, ext: 1'b0});
    send_frame(8'h1C, 1'b0, 11, -1);
    drain();

    // Extended break, then a plain code with flags cleared.
    v0 = n_valid;
    send_frame(8'hE0, 1'b0, 11, -1);
    send_frame(8'hF0, 1'b0, 11, -1);
    q.push_back('{b: 8'h75, brk: 1'b1, ext: 1'b1});
    send_frame(8'h75, 1'b0, 11, -1);
    q.push_back('{b: 8'h1C, brk: 1'b0, ext: 1'b0});
    send_frame(8'h1C, 1'b0, 11, -1);
    drain();
    chk("e0f075_pulse_count", n_valid - v0, 2);

    // Bad parity after a break prefix: rejected, byte held, prefix discarded.
    send_frame(8'hF0, 1'b0, 11, -1);
    f0 = n_ferr;
    v0 = n_valid;
    send_frame(8'h5A, 1'b1, 11, -1);
    repeat (5) @(negedge clk);
    chk("badpar_error", n_ferr - f0, 1);
    chk("badpar_no_valid", n_valid - v0, 0);
    chk("badpar_byte_held", ifc.Kb_Byte, 8'h1C);
    q.push_back('{b: 8'h1C, brk: 1'b0, ext: 1'b0});
    send_frame(8'h1C, 1'b0, 11, -1);
    drain();

    // Timeout after 5 data bits, with an E0 prefix pending beforehand.
    send_frame(8'hE0, 1'b0, 11, -1);
    f0 = n_ferr;
    send_frame(8'h29, 1'b0, 6, -1);
    chk("busy_partial", 32'(ifc.Busy), 1);
    for (int i = 0; i < int'(TO) + 200 && n_ferr == f0; i++) @(negedge clk);
    chk("timeout_error", n_ferr - f0, 1);
    chk("timeout_busy", 32'(ifc.Busy), 0);
    q.push_back('{b: 8'h29, brk: 1'b0, ext: 1'b0});
    send_frame(8'h29, 1'b0, 11, -1);
    drain();

    // Short low glitch during a data bit's high phase.
    q.push_back('{b: 8'h3A, brk: 1'b0, ext: 1'b0});
    send_frame(8'h3A, 1'b0, 11, 3);
    drain();

    // Reset mid-frame clears everything asynchronously.
    send_frame(8'h4B, 1'b0, 4, -1);
    chk("busy_before_reset", 32'(ifc.Busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_busy", 32'(ifc.Busy), 0);
    chk("midreset_byte", ifc.Kb_Byte, 0);
    chk("midreset_valid", 32'(ifc.Kb_Valid), 0);
    chk("midreset_ferr", 32'(ifc.Frame_Error), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    q.push_back('{b: 8'h16, brk: 1'b0, ext: 1'b0});
    send_frame(8'h16, 1'b0, 11, -1);
    drain();

    chk("total_frame_errors", n_ferr, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
